// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: shift-add multiply, restoring divide, sign fix at the end.
// Latency: WIDTH+1 cycles from the sampled start to the done pulse, identical for every funct3.
// No backpressure: start is taken only in IDLE; busy stalls the issuing core until done.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int CW = $clog2(WIDTH) + 1;

    localparam logic [2:0] F_MUL    = 3'b000;
    localparam logic [2:0] F_MULH   = 3'b001;
    localparam logic [2:0] F_MULHSU = 3'b010;
    localparam logic [2:0] F_MULHU  = 3'b011;
    localparam logic [2:0] F_DIV    = 3'b100;
    localparam logic [2:0] F_DIVU   = 3'b101;
    localparam logic [2:0] F_REM    = 3'b110;
    localparam logic [2:0] F_REMU   = 3'b111;

    localparam logic [WIDTH-1:0] MIN_INT = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ALL_ONE = {WIDTH{1'b1}};
    localparam logic [CW-1:0]    LAST    = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2:0]         op_q, op_d;
    logic               neg_a_q, neg_a_d;
    logic               neg_b_q, neg_b_d;
    logic               div_zero_q, div_zero_d;
    logic               ovf_q, ovf_d;
    logic [WIDTH-1:0]   a_mag_q, a_mag_d;
    logic [WIDTH-1:0]   b_mag_q, b_mag_d;
    logic [WIDTH-1:0]   a_raw_q, a_raw_d;
    // Multiply: {partial product high, multiplier shifting out}.
    // Divide:   {partial remainder, dividend shifting out / quotient shifting in}.
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   result_q, result_d;

    // Operand decode for the start cycle
    logic               is_div_in;
    logic               a_signed_in, b_signed_in;
    logic               neg_a_in, neg_b_in;
    logic [WIDTH-1:0]   a_mag_in, b_mag_in;

    // One iteration of each algorithm
    logic [WIDTH-1:0]   mul_addend;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] div_next;

    // Result shaping
    logic               accept;
    logic               last_iter;
    logic [2*WIDTH-1:0] fin_acc;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo, rem;
    logic [WIDTH-1:0]   res_final;

    assign accept    = (state_q == S_IDLE) && start;
    assign last_iter = (state_q == S_RUN) && (cnt_q == LAST);

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start) state_d = S_RUN;
            S_RUN:    if (cnt_q == LAST) state_d = S_FINISH;
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from the state register and the result register only
    always_comb begin
        busy   = (state_q != S_IDLE);
        done   = (state_q == S_FINISH);
        result = result_q;
    end

    // Decode signedness and magnitudes of the incoming operands
    always_comb begin
        is_div_in   = funct3[2];
        a_signed_in = (funct3 == F_MULH) || (funct3 == F_MULHSU) ||
                      (funct3 == F_DIV)  || (funct3 == F_REM);
        b_signed_in = (funct3 == F_MULH) || (funct3 == F_DIV) || (funct3 == F_REM);
        neg_a_in    = a_signed_in && operand_a[WIDTH-1];
        neg_b_in    = b_signed_in && operand_b[WIDTH-1];
        a_mag_in    = neg_a_in ? -operand_a : operand_a;
        b_mag_in    = neg_b_in ? -operand_b : operand_b;
    end

    // One shift-add multiply step and one restoring divide step on the accumulator
    always_comb begin
        mul_addend = acc_q[0] ? a_mag_q : '0;
        mul_sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mul_addend};
        mul_next   = {mul_sum, acc_q[WIDTH-1:1]};

        // Remainder < divisor, so the shifted value fits in WIDTH+1 bits and
        // the top bit of the difference is a clean borrow flag.
        div_shift  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_diff   = div_shift - {1'b0, b_mag_q};
        if (!div_diff[WIDTH]) begin
            div_next = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end else begin
            div_next = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end
    end

    // Final sign fix and special-case selection, applied to the last iteration's output
    always_comb begin
        fin_acc  = op_q[2] ? div_next : mul_next;
        prod_fix = (neg_a_q ^ neg_b_q) ? -fin_acc : fin_acc;
        quo      = fin_acc[WIDTH-1:0];
        rem      = fin_acc[2*WIDTH-1:WIDTH];
        case (op_q)
            F_MUL:                      res_final = prod_fix[WIDTH-1:0];
            F_MULH, F_MULHSU, F_MULHU:  res_final = prod_fix[2*WIDTH-1:WIDTH];
            F_DIV, F_DIVU: begin
                if (div_zero_q)             res_final = ALL_ONE;
                else if (ovf_q)             res_final = MIN_INT;
                else if (neg_a_q ^ neg_b_q) res_final = -quo;
                else                        res_final = quo;
            end
            F_REM, F_REMU: begin
                if (div_zero_q)   res_final = a_raw_q;
                else if (ovf_q)   res_final = '0;
                else if (neg_a_q) res_final = -rem;
                else              res_final = rem;
            end
            default:                    res_final = '0;
        endcase
    end

    // Datapath next-state: latch on accept, iterate in RUN, capture result on the last step
    always_comb begin
        cnt_d      = cnt_q;
        op_d       = op_q;
        neg_a_d    = neg_a_q;
        neg_b_d    = neg_b_q;
        div_zero_d = div_zero_q;
        ovf_d      = ovf_q;
        a_mag_d    = a_mag_q;
        b_mag_d    = b_mag_q;
        a_raw_d    = a_raw_q;
        acc_d      = acc_q;
        result_d   = result_q;
        if (accept) begin
            cnt_d      = '0;
            op_d       = funct3;
            neg_a_d    = neg_a_in;
            neg_b_d    = neg_b_in;
            div_zero_d = is_div_in && (operand_b == '0);
            ovf_d      = ((funct3 == F_DIV) || (funct3 == F_REM)) &&
                         (operand_a == MIN_INT) && (operand_b == ALL_ONE);
            a_mag_d    = a_mag_in;
            b_mag_d    = b_mag_in;
            a_raw_d    = operand_a;
            acc_d      = is_div_in ? {{WIDTH{1'b0}}, a_mag_in} : {{WIDTH{1'b0}}, b_mag_in};
        end else if (state_q == S_RUN) begin
            cnt_d = cnt_q + 1'b1;
            acc_d = fin_acc;
            // Registering here makes result valid in the FINISH cycle itself.
            if (last_iter) begin
                result_d = res_final;
            end
        end else if (state_q == S_FINISH) begin
            cnt_d = '0;
        end
    end

    // Datapath registers
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q      <= '0;
            op_q       <= '0;
            neg_a_q    <= 1'b0;
            neg_b_q    <= 1'b0;
            div_zero_q <= 1'b0;
            ovf_q      <= 1'b0;
            a_mag_q    <= '0;
            b_mag_q    <= '0;
            a_raw_q    <= '0;
            acc_q      <= '0;
            result_q   <= '0;
        end else begin
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            neg_a_q    <= neg_a_d;
            neg_b_q    <= neg_b_d;
            div_zero_q <= div_zero_d;
            ovf_q      <= ovf_d;
            a_mag_q    <= a_mag_d;
            b_mag_q    <= b_mag_d;
            a_raw_q    <= a_raw_d;
            acc_q      <= acc_d;
            result_q   <= result_d;
        end
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide unit for the rvsimple datapath. It accepts two operands and an M-extension funct3 on a one-cycle `start`, computes over a fixed WIDTH-cycle shift/add or shift/subtract loop, and presents a registered `result` with a one-cycle `done` pulse. `result` feeds one channel of the writeback-select multiplexer, directly upstream of the register-file write port. The control unit stalls the core while `busy` is high.

## Interface
Parameters:
- WIDTH, 32, operand/result width (XLEN); must be ≥ 2.

Ports:
- clock  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- funct3  input  3  operation: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- operand_a  input  WIDTH  rs1 value (multiplicand/dividend).
- operand_b  input  WIDTH  rs2 value (multiplier/divisor).
- busy  output  1  high while an operation is in flight.
- done  output  1  one-cycle pulse; `result` is valid this cycle.
- result  output  WIDTH  registered result, held until the next completion.

## Operation
- States: IDLE, RUN, FINISH.
- IDLE: `busy`=0. If `start`=1, latch funct3, operand signs, and operand magnitudes, then go to RUN with counter=0.
  - Signed interpretation: a is signed for MULH, MULHSU, DIV, REM; b is signed for MULH, DIV, REM. All other cases are unsigned.
- RUN: one iteration per cycle. After the iteration with counter=WIDTH-1, go to FINISH.
  - Counter is $clog2(WIDTH)+1 bits wide.
  - Multiply: shift-add into a 2·WIDTH product register on magnitudes.
  - Divide: restoring shift-subtract giving WIDTH-bit quotient and remainder on magnitudes.
- FINISH: apply the result rules below, register `result`, pulse `done`=1, return to IDLE.
  - Multiply sign fix: negate the 2·WIDTH product if the effective signs differ.
  - Divide sign fix: negate the quotient if the signs differ; the remainder takes the sign of the dividend.
  - MUL returns the low WIDTH bits. MULH, MULHSU, MULHU return the high WIDTH bits.
  - Divide by zero (b==0), flagged at latch: DIV/DIVU return all-ones; REM/REMU return operand_a unchanged.
  - Signed overflow (DIV/REM with a=100…0, b=all-ones), flagged at latch: DIV returns 100…0; REM returns 0.
  - Special cases use the same full latency; there is no early exit.
- `start` while `busy`=1 is ignored. Operands need only be stable in the start cycle.
- Reset, at any time including mid-operation, forces IDLE, `busy`=0, `done`=0, `result`=0, counter=0. The in-flight operation is discarded.
- `start` in the same cycle as `reset` is ignored.

## Timing
- `start` sampled at edge T: `busy`=1 from T+1 through T+WIDTH+1 inclusive.
- `done`=1 and `result` valid in cycle T+WIDTH+1 only.
  - Total latency is WIDTH+1 cycles (33 for WIDTH=32) for every funct3.
- `busy` and `done` are both high in the FINISH cycle. `busy` falls at T+WIDTH+2.
- Back-to-back: a `start` present in the cycle after FINISH (IDLE) is accepted. The minimum issue interval is WIDTH+2 cycles.
- `start` during FINISH is ignored.
- All outputs are registered or decoded from the state register only; there is no combinational path from inputs to outputs.

## Test plan
- MUL 7 × 0xFFFFFFFD, start at edge 0: `busy` is high at cycles 1–33, `done` only at cycle 33, `result`=0xFFFFFFEB held afterwards.
- High products:
  - MULH 0x80000000 × 0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- Signed divide:
  - DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD.
  - REM 0xFFFFFFF9 % 2 → 0xFFFFFFFF.
  - DIVU 100 / 7 → 14.
  - REMU 100 % 7 → 2.
- Corner cases, each still at 33-cycle latency:
  - DIVU 5/0 → 0xFFFFFFFF.
  - REM 5/0 → 5.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000.
  - REM of the same operands → 0.
- Protocol:
  - A second `start` (MUL 2×3) at cycle 10 of an in-flight DIV is ignored; only the DIV result appears at cycle 33.
  - An immediate restart at cycle 34 yields its `done` at cycle 67.
- Reset: assert `reset` at cycle 15 of an operation → `busy`=0, `done`=0, `result`=0 from the next cycle, and no `done` at cycle 33. A fresh MULHU afterwards completes normally.
